// File: rtl/product_accumulator.sv
// Sums LEN consecutive unsigned products into an ACC_WIDTH accumulator and presents the sum on a valid/ready port.
// Optional macro PRODUCT_ACCUMULATOR_SATURATE_EN: clamp to all-ones on carry-out instead of wrapping.
module product_accumulator #(
  parameter int SIZE      = 8,
  parameter int LEN       = 4,
  parameter int ACC_WIDTH = 18,
  localparam int CW       = $clog2(LEN+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 prod_valid,
  output logic                 prod_ready,
  input  logic [2*SIZE-1:0]    prod,
  input  logic                 prod_over,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ACC_WIDTH-1:0] res,
  output logic                 res_over,
  output logic [CW-1:0]        beat_cnt
);

  generate
    if (ACC_WIDTH < 2*SIZE) begin : g_chk_w
      $error("product_accumulator: ACC_WIDTH must be >= 2*SIZE");
    end
    if (LEN < 1) begin : g_chk_len
      $error("product_accumulator: LEN must be >= 1");
    end
  endgenerate

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] acc_nxt;
  logic                 accept;
  logic                 last;

  assign prod_ready = (state == ACCUM);
  assign res_valid  = (state == HOLD);
  assign res        = acc;
  assign accept     = prod_valid & prod_ready;
  assign last       = (beat_cnt == CW'(LEN-1));
  assign sum        = {1'b0, acc} + (ACC_WIDTH+1)'(prod);

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  // Once clamped, any further nonzero add carries again, so the clamp sticks.
  assign acc_nxt = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
  assign acc_nxt = sum[ACC_WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCUM;
      acc      <= '0;
      beat_cnt <= '0;
      res_over <= 1'b0;
    end else if (clear) begin
      state    <= ACCUM;
      acc      <= '0;
      beat_cnt <= '0;
      res_over <= 1'b0;
    end else begin
      case (state)
        ACCUM: if (accept) begin
          acc      <= acc_nxt;
          res_over <= res_over | prod_over | sum[ACC_WIDTH];
          beat_cnt <= beat_cnt + 1'b1;
          if (last) state <= HOLD;
        end
        HOLD: if (res_ready) begin
          state    <= ACCUM;
          acc      <= '0;
          beat_cnt <= '0;
          res_over <= 1'b0;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: LEN=4/ACC_WIDTH=18 instance for sequencing, LEN=2/ACC_WIDTH=16 instance for wrap/saturate.
`timescale 1ns/1ps
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        clear = 0, prod_valid = 0, prod_over = 0, res_ready = 0;
  logic [15:0] prod = '0;
  logic        prod_ready, res_valid, res_over;
  logic [17:0] res;
  logic [2:0]  beat_cnt;

  logic        clear2 = 0, prod_valid2 = 0, prod_over2 = 0, res_ready2 = 0;
  logic [15:0] prod2 = '0;
  logic        prod_ready2, res_valid2, res_over2;
  logic [15:0] res2;
  logic [1:0]  beat_cnt2;

  int total = 0;
  int bad   = 0;

  product_accumulator #(.SIZE(8), .LEN(4), .ACC_WIDTH(18)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .prod(prod), .prod_over(prod_over), .res_valid(res_valid), .res_ready(res_ready),
    .res(res), .res_over(res_over), .beat_cnt(beat_cnt));

  product_accumulator #(.SIZE(8), .LEN(2), .ACC_WIDTH(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear2), .prod_valid(prod_valid2), .prod_ready(prod_ready2),
    .prod(prod2), .prod_over(prod_over2), .res_valid(res_valid2), .res_ready(res_ready2),
    .res(res2), .res_over(res_over2), .beat_cnt(beat_cnt2));

  // Four beats on consecutive cycles; returns at the negedge after the last accept.
  task automatic drive_seq(input logic [15:0] p0, p1, p2, p3, input logic [3:0] ov);
    logic [15:0] p [4];
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      prod_valid = 1'b1; prod = p[i]; prod_over = ov[i];
    end
    @(negedge clk);
    prod_valid = 1'b0; prod_over = 1'b0; prod = '0;
  endtask

  task automatic drain();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    total++; if (res !== 18'd0) begin bad++; $display("FAIL reset_res got=%0d exp=0", res); end
    total++; if (beat_cnt !== 3'd0) begin bad++; $display("FAIL reset_beat_cnt got=%0d exp=0", beat_cnt); end
    total++; if (res_over !== 1'b0) begin bad++; $display("FAIL reset_res_over got=%b exp=0", res_over); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if (prod_ready !== 1'b1) begin bad++; $display("FAIL reset_prod_ready got=%b exp=1", prod_ready); end
  endtask

  task automatic test_basic();
    drive_seq(16'd3, 16'd6, 16'd9, 16'd1, 4'b0000);
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL basic_res_valid got=%b exp=1", res_valid); end
    total++; if (res !== 18'd19) begin bad++; $display("FAIL basic_res got=%0d exp=19", res); end
    total++; if (res_over !== 1'b0) begin bad++; $display("FAIL basic_res_over got=%b exp=0", res_over); end
    total++; if (beat_cnt !== 3'd4) begin bad++; $display("FAIL basic_beat_cnt got=%0d exp=4", beat_cnt); end
    total++; if (prod_ready !== 1'b0) begin bad++; $display("FAIL basic_hold_ready got=%b exp=0", prod_ready); end
    drain();
    total++; if (prod_ready !== 1'b1) begin bad++; $display("FAIL basic_drain_ready got=%b exp=1", prod_ready); end
    total++; if (beat_cnt !== 3'd0) begin bad++; $display("FAIL basic_drain_cnt got=%0d exp=0", beat_cnt); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL basic_drain_valid got=%b exp=0", res_valid); end
  endtask

  task automatic test_max();
    drive_seq(16'd65025, 16'd65025, 16'd65025, 16'd65025, 4'b0000);
    total++; if (res !== 18'd260100) begin bad++; $display("FAIL max_res got=%0d exp=260100", res); end
    total++; if (res_over !== 1'b0) begin bad++; $display("FAIL max_res_over got=%b exp=0", res_over); end
    drain();
  endtask

  task automatic test_wrap();
    logic [15:0] exp;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    exp = 16'd65535;
`else
    exp = 16'd64514;
`endif
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); prod_valid2 = 1'b1; prod2 = 16'd65025;
    end
    @(negedge clk); prod_valid2 = 1'b0; prod2 = '0;
    total++; if (res_valid2 !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b exp=1", res_valid2); end
    total++; if (res2 !== exp) begin bad++; $display("FAIL wrap_res got=%0d exp=%0d", res2, exp); end
    total++; if (res_over2 !== 1'b1) begin bad++; $display("FAIL wrap_over got=%b exp=1", res_over2); end
    res_ready2 = 1'b1; @(negedge clk); res_ready2 = 1'b0;
    total++; if (res2 !== 16'd0 || prod_ready2 !== 1'b1) begin bad++; $display("FAIL wrap_drain res=%0d ready=%b exp=0/1", res2, prod_ready2); end
  endtask

  task automatic test_backpressure();
    drive_seq(16'd3, 16'd6, 16'd9, 16'd1, 4'b0000);
    prod_valid = 1'b1; prod = 16'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (prod_ready !== 1'b0 || res !== 18'd19 || beat_cnt !== 3'd4)
        begin bad++; $display("FAIL bp_hold%0d ready=%b res=%0d cnt=%0d exp=0/19/4", i, prod_ready, res, beat_cnt); end
    end
    prod_valid = 1'b0;
    drain();
    drive_seq(16'd1, 16'd1, 16'd1, 16'd1, 4'b0000);
    total++; if (res !== 18'd4) begin bad++; $display("FAIL bp_next_res got=%0d exp=4", res); end
    drain();
  endtask

  task automatic test_overflow_flag();
    drive_seq(16'd2, 16'd2, 16'd2, 16'd2, 4'b0010);
    total++; if (res !== 18'd8) begin bad++; $display("FAIL ovf_res got=%0d exp=8", res); end
    total++; if (res_over !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", res_over); end
    drain();
    drive_seq(16'd2, 16'd2, 16'd2, 16'd2, 4'b0000);
    total++; if (res_over !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", res_over); end
    drain();
  endtask

  task automatic test_clear();
    @(negedge clk); prod_valid = 1'b1; prod = 16'd5;
    @(negedge clk); prod = 16'd7;
    @(negedge clk);
    total++; if (beat_cnt !== 3'd2) begin bad++; $display("FAIL clr_pre_cnt got=%0d exp=2", beat_cnt); end
    clear = 1'b1; prod = 16'd100;
    @(negedge clk); clear = 1'b0; prod_valid = 1'b0; prod = '0;
    total++; if (beat_cnt !== 3'd0 || res !== 18'd0) begin bad++; $display("FAIL clr_state cnt=%0d res=%0d exp=0/0", beat_cnt, res); end
    drive_seq(16'd1, 16'd2, 16'd3, 16'd4, 4'b0000);
    total++; if (res !== 18'd10) begin bad++; $display("FAIL clr_next_res got=%0d exp=10", res); end
    drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); prod_valid = 1'b1; prod = 16'd1;
    end
    @(negedge clk); prod_valid = 1'b0; prod = '0;
    total++; if (beat_cnt !== 3'd3) begin bad++; $display("FAIL arst_pre_cnt got=%0d exp=3", beat_cnt); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (beat_cnt !== 3'd0 || res !== 18'd0 || res_valid !== 1'b0)
      begin bad++; $display("FAIL arst_now cnt=%0d res=%0d vld=%b exp=0/0/0", beat_cnt, res, res_valid); end
    @(negedge clk); rst_n = 1'b1;
    drive_seq(16'd1, 16'd1, 16'd1, 16'd1, 4'b0000);
    total++; if (res !== 18'd4) begin bad++; $display("FAIL arst_next_res got=%0d exp=4", res); end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_wrap();
    test_backpressure();
    test_overflow_flag();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
